// File: rtl/memory_arbiter.sv
// Independent round-robin read and write arbiters sharing one simple dual-port
// memory; read data returns one cycle after the grant, qualified per requester.
module memory_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MEM_SIZE  = 6,
  parameter int ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]  rd_addr,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]  wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     wr_data,
  output logic [NUM_REQ-1:0]            wr_gnt,
  output logic                          mem_read,
  output logic [ADDR_SIZE-1:0]          mem_addr_r,
  output logic                          mem_write,
  output logic [ADDR_SIZE-1:0]          mem_addr_w,
  output logic [DATA_W-1:0]             mem_datain,
  input  logic [DATA_W-1:0]             mem_dataout
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  // Returns {found, winner}: first asserted request scanning upward from ptr.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [PTR_W-1:0]   ptr);
    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W-1:0]   rd_win, wr_win;
  logic               rd_found, wr_found;
  logic [NUM_REQ-1:0] rd_valid_q;

  always_comb begin
    {rd_found, rd_win} = rr_pick(rd_req, rd_ptr);
    {wr_found, wr_win} = rr_pick(wr_req, wr_ptr);
  end

  assign rd_gnt = (rd_found && !reset) ? (NUM_REQ'(1) << rd_win) : '0;
  assign wr_gnt = (wr_found && !reset) ? (NUM_REQ'(1) << wr_win) : '0;

  assign mem_read   = |rd_gnt;
  assign mem_addr_r = mem_read ? rd_addr[int'(rd_win)*ADDR_SIZE +: ADDR_SIZE] : '0;
  assign mem_write  = |wr_gnt;
  assign mem_addr_w = mem_write ? wr_addr[int'(wr_win)*ADDR_SIZE +: ADDR_SIZE] : '0;
  assign mem_datain = mem_write ? wr_data[int'(wr_win)*DATA_W +: DATA_W] : '0;

  assign rd_data = mem_dataout;
  // A read granted just before reset must not surface during the reset cycle.
  assign rd_valid = rd_valid_q & {NUM_REQ{~reset}};

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rd_valid_q <= '0;
    end else begin
      if (rd_found) rd_ptr <= (rd_win == LAST) ? '0 : rd_win + 1'b1;
      if (wr_found) wr_ptr <= (wr_win == LAST) ? '0 : wr_win + 1'b1;
      rd_valid_q <= rd_gnt;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: behavioural memory plus a reference model of the
// arbitration rules, directed plan steps followed by randomized traffic.
module tb_memory_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MS = 6;
  localparam int AW = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    rd_req, wr_req;
  logic [N*AW-1:0] rd_addr, wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    rd_gnt, rd_valid, wr_gnt;
  logic [DW-1:0]   rd_data;
  logic            mem_read, mem_write;
  logic [AW-1:0]   mem_addr_r, mem_addr_w;
  logic [DW-1:0]   mem_datain, mem_dataout;

  logic [AW-1:0] ra [N];
  logic [AW-1:0] wa [N];
  logic [DW-1:0] wd [N];

  int compared = 0;
  int mismatched = 0;

  memory_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MEM_SIZE(MS)) dut (
    .clock(clock), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .mem_read(mem_read), .mem_addr_r(mem_addr_r),
    .mem_write(mem_write), .mem_addr_w(mem_addr_w), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout)
  );

  always #5 clock = ~clock;

  always_comb begin
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < N; i++) begin
      rd_addr[i*AW +: AW] = ra[i];
      wr_addr[i*AW +: AW] = wa[i];
      wr_data[i*DW +: DW] = wd[i];
    end
  end

  // Behavioural memory: registered read, out-of-range reads give 0, writes dropped.
  logic [DW-1:0] mem [MS];
  bit inited = 1'b0;
  always @(posedge clock) begin
    if (!inited) begin
      for (int i = 0; i < MS; i++) mem[i] <= 8'h10 + 8'(i);
      inited <= 1'b1;
    end else if (mem_write && int'(mem_addr_w) < MS) begin
      mem[mem_addr_w] <= mem_datain;
    end
    if (mem_read) mem_dataout <= (int'(mem_addr_r) < MS) ? mem[mem_addr_r] : '0;
  end

  // Reference model state
  int            m_rptr, m_wptr;
  logic [N-1:0]  m_valid;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [MS];
  logic [N-1:0]  obs_rg, obs_wg, obs_rv;
  logic [DW-1:0] obs_rd;

  // Winner = requester at the smallest circular distance from the pointer.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++)
      if (req[i] && ((i - ptr + N) % N) < bd) begin
        bd = (i - ptr + N) % N;
        best = i;
      end
    return best;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int rw, ww;
    logic [N-1:0] erg, ewg, erv;
    @(negedge clock);
    rw  = reset ? -1 : pick(rd_req, m_rptr);
    ww  = reset ? -1 : pick(wr_req, m_wptr);
    erg = (rw < 0) ? '0 : N'(1 << rw);
    ewg = (ww < 0) ? '0 : N'(1 << ww);
    erv = reset ? '0 : m_valid;
    chk("rd_gnt", 32'(rd_gnt), 32'(erg));
    chk("wr_gnt", 32'(wr_gnt), 32'(ewg));
    chk("mem_read", 32'(mem_read), 32'(rw >= 0));
    chk("mem_write", 32'(mem_write), 32'(ww >= 0));
    chk("mem_addr_r", 32'(mem_addr_r), (rw < 0) ? 32'd0 : 32'(ra[rw]));
    chk("mem_addr_w", 32'(mem_addr_w), (ww < 0) ? 32'd0 : 32'(wa[ww]));
    chk("mem_datain", 32'(mem_datain), (ww < 0) ? 32'd0 : 32'(wd[ww]));
    chk("rd_valid", 32'(rd_valid), 32'(erv));
    if (erv != '0) chk("rd_data", 32'(rd_data), 32'(m_rdata));
    obs_rg = rd_gnt; obs_wg = wr_gnt; obs_rv = rd_valid; obs_rd = rd_data;
    @(posedge clock);
    if (reset) begin
      m_rptr = 0; m_wptr = 0; m_valid = '0;
    end else begin
      if (rw >= 0) begin
        m_rdata = (int'(ra[rw]) < MS) ? ref_mem[ra[rw]] : '0;
        m_rptr  = (rw + 1) % N;
      end
      m_valid = erg;
      if (ww >= 0) begin
        if (int'(wa[ww]) < MS) ref_mem[wa[ww]] = wd[ww];
        m_wptr = (ww + 1) % N;
      end
    end
    #1;
  endtask

  task automatic idle();
    rd_req = '0; wr_req = '0;
  endtask

  initial begin
    for (int i = 0; i < MS; i++) ref_mem[i] = 8'h10 + 8'(i);
    for (int i = 0; i < N; i++) begin ra[i] = '0; wa[i] = '0; wd[i] = '0; end
    m_rptr = 0; m_wptr = 0; m_valid = '0; m_rdata = '0;

    // Reset with all requests high
    reset = 1'b1; rd_req = '1; wr_req = '1;
    cycle(); cycle();
    chk("reset_rd_gnt", 32'(obs_rg), 32'd0);
    reset = 1'b0;
    cycle();
    chk("first_rd_gnt", 32'(obs_rg), 32'b0001);
    chk("first_wr_gnt", 32'(obs_wg), 32'b0001);

    // Write 0xA5 to addr 3 by req 2, read back by req 1
    idle(); wr_req = 4'b0100; wa[2] = 3'd3; wd[2] = 8'hA5;
    cycle();
    chk("plan_wr_gnt", 32'(obs_wg), 32'b0100);
    idle(); cycle();
    rd_req = 4'b0010; ra[1] = 3'd3;
    cycle();
    chk("plan_rd_gnt", 32'(obs_rg), 32'b0010);
    idle(); cycle();
    chk("plan_rd_valid", 32'(obs_rv), 32'b0010);
    chk("plan_rd_data", 32'(obs_rd), 32'hA5);

    // Round-robin order from a fresh pointer
    reset = 1'b1; cycle(); reset = 1'b0;
    rd_req = '1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_order", 32'(obs_rg), 32'(1 << (k % N)));
      if (k > 0) chk("rr_valid_trail", 32'(obs_rv), 32'(1 << ((k - 1) % N)));
    end
    idle(); cycle();

    // Same-cycle read/write to addr 1 returns the old word
    wr_req = 4'b0001; wa[0] = 3'd1; wd[0] = 8'h3C;
    rd_req = 4'b1000; ra[3] = 3'd1;
    cycle();
    wr_req = '0;
    cycle();
    chk("rw_old_valid", 32'(obs_rv), 32'b1000);
    chk("rw_old_data", 32'(obs_rd), 32'h11);
    idle(); cycle();
    chk("rw_new_data", 32'(obs_rd), 32'h3C);

    // Out-of-range read (7) and write (6)
    rd_req = 4'b0010; ra[1] = 3'd7;
    wr_req = 4'b0010; wa[1] = 3'd6; wd[1] = 8'hEE;
    cycle();
    chk("oor_wr_gnt", 32'(obs_wg), 32'b0010);
    idle(); cycle();
    chk("oor_rd_valid", 32'(obs_rv), 32'b0010);
    chk("oor_rd_data", 32'(obs_rd), 32'd0);
    for (int i = 0; i < MS; i++) chk("mem_contents", 32'(mem[i]), 32'(ref_mem[i]));

    // Read granted, then reset on the next cycle
    rd_req = 4'b0100; ra[2] = 3'd0;
    cycle();
    chk("pre_reset_gnt", 32'(obs_rg), 32'b0100);
    idle(); reset = 1'b1;
    cycle();
    chk("reset_kill_valid", 32'(obs_rv), 32'd0);
    reset = 1'b0; rd_req = '1; wr_req = '1;
    cycle();
    chk("post_reset_rd_gnt", 32'(obs_rg), 32'b0001);
    chk("post_reset_valid", 32'(obs_rv), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      reset  = ($urandom_range(0, 49) == 0);
      rd_req = N'($urandom);
      wr_req = N'($urandom);
      for (int i = 0; i < N; i++) begin
        ra[i] = AW'($urandom);
        wa[i] = AW'($urandom);
        wd[i] = DW'($urandom);
      end
      cycle();
    end
    reset = 1'b0; idle(); cycle();
    for (int i = 0; i < MS; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Round-robin arbiter that shares one simple dual-port memory (one write port, one read port, registered read data) between `NUM_REQ` requesters. Read and write ports are arbitrated independently, so one read and one write can be granted in the same cycle. The block sits between the client logic and the memory: it drives the memory's `read`/`write`/`addr_r`/`addr_w`/`datain` and returns `dataout` to the requester that issued the read.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: data width; matches the memory.
- `MEM_SIZE`, 6: memory depth in words.
- `ADDR_SIZE`, `$clog2(MEM_SIZE)`: address width.
- `clock` in 1: single clock; all state updates on its posedge.
- `reset` in 1: synchronous, active-high.
- `rd_req` in NUM_REQ: per-requester read request, level, held until granted.
- `rd_addr` in NUM_REQ*ADDR_SIZE: flattened read addresses; requester i uses slice [i*ADDR_SIZE +: ADDR_SIZE].
- `rd_gnt` out NUM_REQ: one-hot read grant, same cycle as the accepted request.
- `rd_valid` out NUM_REQ: one-hot, one cycle after `rd_gnt`, qualifies `rd_data`.
- `rd_data` out DATA_W: memory `dataout`, broadcast to all requesters.
- `wr_req` in NUM_REQ: per-requester write request, level, held until granted.
- `wr_addr` in NUM_REQ*ADDR_SIZE: flattened write addresses.
- `wr_data` in NUM_REQ*DATA_W: flattened write data.
- `wr_gnt` out NUM_REQ: one-hot write grant; the write commits at this clock edge.
- `mem_read` out 1, `mem_addr_r` out ADDR_SIZE: memory read strobe and address.
- `mem_write` out 1, `mem_addr_w` out ADDR_SIZE, `mem_datain` out DATA_W: memory write strobe, address and data.
- `mem_dataout` in DATA_W: memory registered read data.

## Operation
- Two identical round-robin arbiters, one for read and one for write. Each holds a priority pointer `ptr` (0..NUM_REQ-1).
- Selection is combinational. The winner is the first asserted request found when scanning from `ptr` upward, modulo NUM_REQ. `*_gnt` is one-hot to the winner, or all-zero when there are no requests.
- On a grant, at the next edge `ptr <= winner + 1`, wrapping from NUM_REQ-1 to 0. With no grant, `ptr` holds its value.
- Read path:
  - `mem_read = |rd_gnt`.
  - `mem_addr_r` = winner's `rd_addr`. It is 0 when there is no grant.
  - A registered `rd_valid <= rd_gnt` routes the returning data to the winner.
  - `rd_data = mem_dataout`, with no extra register.
- Write path:
  - `mem_write = |wr_gnt`.
  - `mem_addr_w` and `mem_datain` come from the winner's slices. Both are 0 when there is no grant.
- Out-of-range addresses (>= MEM_SIZE) are granted normally.
  - A read returns 0 (memory behaviour); `rd_valid` still pulses.
  - A write is dropped by the memory; `wr_gnt` still pulses.
- Simultaneous read and write to the same address in one cycle: both are granted, and the read returns the old word.
- A requester may hold `rd_req` and `wr_req` at the same time. The two grants are independent.
- A requester that keeps its request asserted after a grant competes again. Round-robin guarantees that any pending request is granted within NUM_REQ cycles.

## Timing
- Reset, sampled at the posedge:
  - `ptr` (both arbiters) <= 0.
  - `rd_valid` <= 0.
  - While `reset` is high, `rd_gnt`, `wr_gnt`, `mem_read` and `mem_write` are forced to 0.
- Reset mid-operation: a read granted in the cycle before reset asserts produces no `rd_valid`. Requesters reissue after reset.
- Latencies:
  - Write: grant and commit happen at the same edge.
  - Read: `rd_gnt` in cycle N, `rd_valid`/`rd_data` in cycle N+1.
  - Back-to-back reads give one read per cycle.
- There is no combinational path from any memory input to any `*_gnt`.
- The combinational path runs from the `*_req`/addr/data inputs to the `mem_*` outputs.

## Test plan
- Reset with all requests high, then release. Required: grants and strobes are 0 during reset; on the first cycle after release, `rd_gnt=0001` and `wr_gnt=0001`.
- Requester 2 writes 0xA5 to addr 3. Two cycles later requester 1 reads addr 3. Required: `wr_gnt=0100`, then `rd_gnt=0010`, then next cycle `rd_valid=0010` and `rd_data=0xA5`.
- All four requesters hold `rd_req` for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3, with `rd_valid` trailing by one cycle.
- In the same cycle, requester 0 writes 0x3C to addr 1 (old value 0x11) and requester 3 reads addr 1. Required: the read returns 0x11, and a read on the following cycle returns 0x3C.
- Requester 1 reads addr 7 (out of range) and requester 1 writes addr 6. Required: `rd_valid=0010`, `rd_data=0`, `wr_gnt=0010`, and the contents of addrs 0..5 are unchanged.
- Read granted to requester 2, with `reset` asserted the next cycle. Required: `rd_valid` stays 0 and `ptr` returns to 0, so the next grant goes to requester 0.
